// File: rtl/scanline_buffer.sv
// Ping-pong scanline store: draw engines fill one bank while the display reads the other,
// getting sprite-over-tile composited pixels with clear-on-read; banks swap on each switch toggle.
module scanline_buffer #(
    parameter int H_PIXELS  = 640,
    parameter int TILE_W    = 16,
    parameter int PIX_W     = 16,
    parameter int TILE_COLS = 40
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_switch,
    input  logic                    i_wr_tile_en,
    input  logic [5:0]              i_wr_tile_col,
    input  logic [TILE_W*PIX_W-1:0] i_wr_tile_data,
    input  logic                    i_wr_pix_en,
    input  logic [9:0]              i_wr_pix_col,
    input  logic [PIX_W-1:0]        i_wr_pix_data,
    input  logic                    i_rd_en,
    input  logic [9:0]              i_rd_col,
    output logic [PIX_W-1:0]        o_rd_pixel,
    output logic                    o_disp_sel,
    output logic                    o_init_done
);
    localparam logic [0:0]       ST_CLEAR = 1'b0;
    localparam logic [0:0]       ST_RUN   = 1'b1;
    localparam logic [9:0]       PIX_LIM  = 10'(H_PIXELS);
    localparam logic [9:0]       PIX_LAST = 10'(H_PIXELS - 1);
    localparam logic [5:0]       TILE_LIM = 6'(TILE_COLS);
    localparam logic [PIX_W-1:0] TRANSP   = {1'b1, {(PIX_W-1){1'b0}}};

    logic [0:0]       r_state;
    logic [9:0]       r_clr_ptr;
    logic             r_switch_q;
    logic             r_disp_sel;
    logic [PIX_W-1:0] r_rd_pixel;

    logic [PIX_W-1:0]        r_spr0  [0:H_PIXELS-1];
    logic [PIX_W-1:0]        r_spr1  [0:H_PIXELS-1];
    logic [TILE_W*PIX_W-1:0] r_tile0 [0:TILE_COLS-1];
    logic [TILE_W*PIX_W-1:0] r_tile1 [0:TILE_COLS-1];

    logic                    w_run;
    logic                    w_toggle;
    logic                    w_tile_wr;
    logic                    w_pix_wr;
    logic                    w_rd_hit;
    logic [PIX_W-1:0]        w_spr_rd;
    logic [TILE_W*PIX_W-1:0] w_tile_word;
    logic [PIX_W-1:0]        w_tile_pix;
    logic [PIX_W-1:0]        w_comp;

    assign w_run     = (r_state == ST_RUN);
    assign w_toggle  = i_switch ^ r_switch_q;
    assign w_tile_wr = w_run & i_wr_tile_en & (i_wr_tile_col < TILE_LIM);
    assign w_pix_wr  = w_run & i_wr_pix_en & (i_wr_pix_col < PIX_LIM) & ~i_wr_pix_data[PIX_W-1];
    assign w_rd_hit  = w_run & i_rd_en & (i_rd_col < PIX_LIM);

    assign w_spr_rd    = r_disp_sel ? r_spr1[i_rd_col] : r_spr0[i_rd_col];
    assign w_tile_word = r_disp_sel ? r_tile1[i_rd_col[9:4]] : r_tile0[i_rd_col[9:4]];
    assign w_tile_pix  = w_tile_word[{i_rd_col[3:0], 4'b0000} +: PIX_W];
    assign w_comp      = w_spr_rd[PIX_W-1] ? w_tile_pix : w_spr_rd;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= ST_CLEAR;
            r_clr_ptr  <= '0;
            r_switch_q <= 1'b0;
            r_disp_sel <= 1'b0;
            r_rd_pixel <= '0;
        end else begin
            r_switch_q <= i_switch;
            if (r_state == ST_CLEAR) begin
                r_clr_ptr <= r_clr_ptr + 10'd1;
                if (r_clr_ptr == PIX_LAST) begin
                    r_state <= ST_RUN;
                end
            end else begin
                if (w_toggle) begin
                    r_disp_sel <= ~r_disp_sel;
                end
                if (i_rd_en) begin
                    r_rd_pixel <= w_rd_hit ? w_comp : '0;
                end
            end
        end
    end

    // Each sprite bank has one write per cycle: the displayed bank only sees read-clears,
    // the draw bank only sees draw writes, so the two sources never compete.
    always_ff @(posedge i_clk) begin
        if (!w_run) begin
            r_spr0[r_clr_ptr] <= TRANSP;
        end else if (w_rd_hit && !r_disp_sel) begin
            r_spr0[i_rd_col] <= TRANSP;
        end else if (w_pix_wr && r_disp_sel) begin
            r_spr0[i_wr_pix_col] <= i_wr_pix_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!w_run) begin
            r_spr1[r_clr_ptr] <= TRANSP;
        end else if (w_rd_hit && r_disp_sel) begin
            r_spr1[i_rd_col] <= TRANSP;
        end else if (w_pix_wr && !r_disp_sel) begin
            r_spr1[i_wr_pix_col] <= i_wr_pix_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_tile_wr && r_disp_sel) begin
            r_tile0[i_wr_tile_col] <= i_wr_tile_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_tile_wr && !r_disp_sel) begin
            r_tile1[i_wr_tile_col] <= i_wr_tile_data;
        end
    end

    assign o_rd_pixel  = r_rd_pixel;
    assign o_disp_sel  = r_disp_sel;
    assign o_init_done = w_run;

endmodule
